// File: rtl/global_mem.sv
// global_mem: off-die global memory model for the GPU card.
// Word-organised storage behind a single-request handshake. Every accepted
// request completes exactly MEM_LATENCY cycles after acceptance, so the
// die-side stall logic is exercised the way real DRAM would exercise it.
// Faulting requests (read+write together, misaligned, out of range) are
// acknowledged at the normal latency with err=1 and rd_data=0.
// Optional feature macro: GLOBAL_MEM_STATS_EN adds rd_count / wr_count /
// err_count saturating request counters.
module global_mem #(
    parameter int data_width  = 32,
    parameter int addr_width  = 32,
    parameter int MEM_WORDS   = 4096,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] wr_data,
    output logic                  busy,
    output logic                  ack,
    output logic                  err,
    output logic [data_width-1:0] rd_data
`ifdef GLOBAL_MEM_STATS_EN
    ,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic [31:0]           err_count
`endif
);

    // Word index width inside the array.
    localparam int IDX_W = $clog2(MEM_WORDS);
    // The down-counter only covers the WAIT cycles: MEM_LATENCY-1 of them,
    // loaded with MEM_LATENCY-2 and leaving WAIT when it reaches zero.
    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);
    // First word index that lies outside the array.
    localparam logic [addr_width-3:0] IDX_LIMIT = (addr_width - 2)'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A request faults when both strobes are high, the byte address is not
    // word aligned, or the word index is beyond the array.
    function automatic logic f_req_fault(input logic                  i_rd,
                                         input logic                  i_wr,
                                         input logic [addr_width-1:0] i_a);
        logic w_both;
        logic w_misaligned;
        logic w_oor;
        w_both       = i_rd & i_wr;
        w_misaligned = (i_a[1:0] != 2'b00);
        w_oor        = (i_a[addr_width-1:2] >= IDX_LIMIT);
        return w_both | w_misaligned | w_oor;
    endfunction

`ifdef GLOBAL_MEM_STATS_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] f_sat_inc(input logic [31:0] i_v);
        logic [31:0] w_res;
        if (i_v == 32'hFFFF_FFFF) begin
            w_res = i_v;
        end else begin
            w_res = i_v + 32'd1;
        end
        return w_res;
    endfunction
`endif

    // State and control registers.
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_ack;
    logic                  r_err;
    logic [data_width-1:0] r_rd_data;
    // Result of the in-flight request, captured at acceptance.
    logic                  r_pend_err;
    logic                  r_pend_upd;
    logic [data_width-1:0] r_pend_data;
    // Storage array; deliberately not reset.
    logic [data_width-1:0] r_mem [MEM_WORDS];

    // Combinational nets.
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_accept;
    logic                  w_fault;
    logic                  w_good_rd;
    logic                  w_good_wr;
    logic [data_width-1:0] w_acc_data;
    logic                  w_acc_err;
    logic                  w_acc_upd;
    logic [data_width-1:0] w_load_data;
    logic                  w_load_err;
    logic                  w_load_upd;
    logic                  w_busy_nxt;
    logic                  w_ack_nxt;
    logic                  w_err_nxt;
    logic [data_width-1:0] w_rd_data_nxt;

    assign w_idx   = addr[IDX_W+1:2];
    assign busy    = r_busy;
    assign ack     = r_ack;
    assign err     = r_err;
    assign rd_data = r_rd_data;

    // Classify the presented request and fetch the read word at acceptance.
    always_comb begin
        w_accept  = ~r_busy & (rd_req | wr_req);
        w_fault   = f_req_fault(rd_req, wr_req, addr);
        w_good_rd = w_accept & rd_req & ~w_fault;
        w_good_wr = w_accept & wr_req & ~w_fault;
        w_acc_err = w_fault;
        // Reads and faults both refresh rd_data at their ack; writes do not.
        w_acc_upd = rd_req | w_fault;
        if (w_good_rd) begin
            w_acc_data = r_mem[w_idx];
        end else begin
            w_acc_data = '0;
        end
    end

    // Next-state logic: IDLE/DONE accept, WAIT counts down to the ack cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (MEM_LATENCY > 1) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        // Single-cycle latency: ack in the very next cycle.
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = r_cnt;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = r_cnt;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = r_cnt;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode of the next state; a same-edge acceptance supplies the
    // result directly so single-cycle latency needs no special path.
    always_comb begin
        if (w_accept) begin
            w_load_data = w_acc_data;
            w_load_err  = w_acc_err;
            w_load_upd  = w_acc_upd;
        end else begin
            w_load_data = r_pend_data;
            w_load_err  = r_pend_err;
            w_load_upd  = r_pend_upd;
        end
        w_busy_nxt = (w_state_nxt == S_WAIT);
        w_ack_nxt  = (w_state_nxt == S_DONE);
        w_err_nxt  = w_ack_nxt & w_load_err;
        if (w_ack_nxt && w_load_upd) begin
            w_rd_data_nxt = w_load_data;
        end else begin
            w_rd_data_nxt = r_rd_data;
        end
    end

    // State register, WAIT counter and captured request result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pend_err  <= 1'b0;
            r_pend_upd  <= 1'b0;
            r_pend_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_pend_err  <= w_acc_err;
                r_pend_upd  <= w_acc_upd;
                r_pend_data <= w_acc_data;
            end else begin
                r_pend_err  <= r_pend_err;
                r_pend_upd  <= r_pend_upd;
                r_pend_data <= r_pend_data;
            end
        end
    end

    // Registered handshake outputs and held read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_rd_data <= w_rd_data_nxt;
        end
    end

    // Storage write at the acceptance edge of a good write.
    always_ff @(posedge clk) begin
        if (rst && w_good_wr) begin
            r_mem[w_idx] <= wr_data;
        end
    end

`ifdef GLOBAL_MEM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;
    logic [31:0] r_err_count;

    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;
    assign err_count = r_err_count;

    // Saturating counters of accepted requests; dropped requests never count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_count  <= 32'd0;
            r_wr_count  <= 32'd0;
            r_err_count <= 32'd0;
        end else begin
            r_rd_count  <= w_good_rd ? f_sat_inc(r_rd_count) : r_rd_count;
            r_wr_count  <= w_good_wr ? f_sat_inc(r_wr_count) : r_wr_count;
            r_err_count <= (w_accept && w_fault) ? f_sat_inc(r_err_count) : r_err_count;
        end
    end
`endif

endmodule

// File: tb/tb_global_mem.sv
// Bench for global_mem: two instances (MEM_LATENCY=4 and MEM_LATENCY=1) share
// one directed stimulus stream. A transaction-level model computes, for each
// instance, when each accepted request must be acknowledged and with what
// result; every cycle the outputs are compared against it. Literal checks
// from hand-worked timelines pin the model.
module tb_global_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;

    logic        busy_o [2];
    logic        ack_o  [2];
    logic        err_o  [2];
    logic [31:0] rd_o   [2];
`ifdef GLOBAL_MEM_STATS_EN
    logic [31:0] rdc_o  [2];
    logic [31:0] wrc_o  [2];
    logic [31:0] errc_o [2];
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    global_mem #(.MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
        .addr(addr), .wr_data(wr_data),
        .busy(busy_o[0]), .ack(ack_o[0]), .err(err_o[0]), .rd_data(rd_o[0])
`ifdef GLOBAL_MEM_STATS_EN
        , .rd_count(rdc_o[0]), .wr_count(wrc_o[0]), .err_count(errc_o[0])
`endif
    );

    global_mem #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
        .addr(addr), .wr_data(wr_data),
        .busy(busy_o[1]), .ack(ack_o[1]), .err(err_o[1]), .rd_data(rd_o[1])
`ifdef GLOBAL_MEM_STATS_EN
        , .rd_count(rdc_o[1]), .wr_count(wrc_o[1]), .err_count(errc_o[1])
`endif
    );

    // ---------------- transaction model ----------------
    int          lat_m [2] = '{4, 1};
    longint      e_cnt = 0;
    logic        m_busy [2];
    logic        m_ack  [2];
    logic        m_err  [2];
    logic [31:0] m_rd   [2];
    logic        m_known[2];
    logic        m_pend [2];
    longint      m_ack_e[2];
    logic        r_err_m [2];
    logic        r_upd_m [2];
    logic        r_known_m [2];
    logic [31:0] r_data_m [2];
    logic [31:0] m_rdc [2];
    logic [31:0] m_wrc [2];
    logic [31:0] m_errc[2];
    logic [31:0] mem_m [longint];

    // Apply the rules for one rising edge to instance s.
    task automatic model_edge(input int s);
        logic   fault;
        longint key;
        if (!rst) begin
            m_busy[s] = 1'b0; m_ack[s] = 1'b0; m_err[s] = 1'b0;
            m_rd[s] = 32'd0; m_known[s] = 1'b1; m_pend[s] = 1'b0;
            m_rdc[s] = 32'd0; m_wrc[s] = 32'd0; m_errc[s] = 32'd0;
            return;
        end
        m_ack[s] = 1'b0;
        m_err[s] = 1'b0;
        if (!m_busy[s] && (rd_req || wr_req)) begin
            fault = (rd_req && wr_req) || (addr[1:0] != 2'd0) || (addr[31:2] >= 30'd4096);
            key   = (longint'(s) << 32) | longint'(addr[31:2]);
            if (fault) begin
                r_err_m[s] = 1'b1; r_upd_m[s] = 1'b1;
                r_data_m[s] = 32'd0; r_known_m[s] = 1'b1;
                m_errc[s] = m_errc[s] + 32'd1;
            end else if (wr_req) begin
                mem_m[key] = wr_data;
                r_err_m[s] = 1'b0; r_upd_m[s] = 1'b0;
                r_data_m[s] = 32'd0; r_known_m[s] = 1'b1;
                m_wrc[s] = m_wrc[s] + 32'd1;
            end else begin
                r_err_m[s] = 1'b0; r_upd_m[s] = 1'b1;
                r_known_m[s] = mem_m.exists(key);
                r_data_m[s] = r_known_m[s] ? mem_m[key] : 32'd0;
                m_rdc[s] = m_rdc[s] + 32'd1;
            end
            m_pend[s]  = 1'b1;
            m_ack_e[s] = e_cnt + longint'(lat_m[s]) - 64'sd1;
        end
        if (m_pend[s] && m_ack_e[s] == e_cnt) begin
            m_ack[s] = 1'b1;
            m_err[s] = r_err_m[s];
            if (r_upd_m[s]) begin
                m_rd[s]    = r_data_m[s];
                m_known[s] = r_known_m[s];
            end
            m_pend[s] = 1'b0;
        end
        m_busy[s] = m_pend[s] && (m_ack_e[s] > e_cnt);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] b2w(input logic b);
        return {31'd0, b};
    endfunction

    // One cycle: drive inputs, advance the model at the edge, compare after.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic rs);
        rd_req = rd; wr_req = wr; addr = a; wr_data = d; rst = rs;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        e_cnt++;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("busy L%0d t%0d", lat_m[s], e_cnt), b2w(busy_o[s]), b2w(m_busy[s]));
            chk($sformatf("ack L%0d t%0d",  lat_m[s], e_cnt), b2w(ack_o[s]),  b2w(m_ack[s]));
            chk($sformatf("err L%0d t%0d",  lat_m[s], e_cnt), b2w(err_o[s]),  b2w(m_err[s]));
            if (m_known[s]) begin
                chk($sformatf("rd_data L%0d t%0d", lat_m[s], e_cnt), rd_o[s], m_rd[s]);
            end
`ifdef GLOBAL_MEM_STATS_EN
            chk($sformatf("rd_count L%0d t%0d",  lat_m[s], e_cnt), rdc_o[s],  m_rdc[s]);
            chk($sformatf("wr_count L%0d t%0d",  lat_m[s], e_cnt), wrc_o[s],  m_wrc[s]);
            chk($sformatf("err_count L%0d t%0d", lat_m[s], e_cnt), errc_o[s], m_errc[s]);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    // Present a request for one cycle, then idle until the latency-4 ack cycle.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        step(rd, wr, a, d, 1'b1);
        idle(3);
    endtask

    int acks;

    initial begin
        rd_req = 1'b0; wr_req = 1'b0; addr = 32'd0; wr_data = 32'd0; rst = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("reset busy", b2w(busy_o[0]), 32'd0);
        chk("reset ack",  b2w(ack_o[0]),  32'd0);
        chk("reset rd_data", rd_o[0], 32'd0);

        // Write DEADBEEF @0x100 at cycle 0: busy cycles 1-3, ack at cycle 4.
        step(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        chk("wr busy c1", b2w(busy_o[0]), 32'd1);
        chk("wr L1 ack c1", b2w(ack_o[1]), 32'd1);
        chk("wr L1 busy c1", b2w(busy_o[1]), 32'd0);
        idle(2);
        chk("wr busy c3", b2w(busy_o[0]), 32'd1);
        idle(1);
        chk("wr ack c4",  b2w(ack_o[0]),  32'd1);
        chk("wr err c4",  b2w(err_o[0]),  32'd0);
        chk("wr busy c4", b2w(busy_o[0]), 32'd0);
        // Read issued in the ack cycle: ack at cycle 8 with the written word.
        req(1'b1, 1'b0, 32'h100, 32'd0);
        chk("rd ack c8", b2w(ack_o[0]), 32'd1);
        chk("rd data c8", rd_o[0], 32'hDEADBEEF);

        // Read at cycle 2 of an in-flight write is dropped: exactly one ack.
        acks = 0;
        step(1'b0, 1'b1, 32'h200, 32'h12345678, 1'b1);
        acks += int'(ack_o[0]);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        acks += int'(ack_o[0]);
        step(1'b1, 1'b0, 32'h200, 32'd0, 1'b1);
        acks += int'(ack_o[0]);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            acks += int'(ack_o[0]);
        end
        chk("dropped read single ack", acks, 32'd1);
        chk("dropped read rd_data held", rd_o[0], 32'hDEADBEEF);

        // Faults: misaligned, out of range, both strobes.
        req(1'b1, 1'b0, 32'h102, 32'd0);
        chk("misaligned ack", b2w(ack_o[0]), 32'd1);
        chk("misaligned err", b2w(err_o[0]), 32'd1);
        chk("misaligned rd_data", rd_o[0], 32'd0);
        req(1'b1, 1'b0, 32'h100, 32'd0);
        chk("reread after fault", rd_o[0], 32'hDEADBEEF);
        req(1'b1, 1'b0, 32'h4000, 32'd0);
        chk("oor err", b2w(err_o[0]), 32'd1);
        chk("oor rd_data", rd_o[0], 32'd0);
        req(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
        req(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF);
        chk("both err", b2w(err_o[0]), 32'd1);
        req(1'b1, 1'b0, 32'h0, 32'd0);
        chk("word0 unchanged", rd_o[0], 32'hA5A5A5A5);
        chk("word0 read err", b2w(err_o[0]), 32'd0);

        // Reset mid-flight: no ack, storage keeps the accepted write.
        step(1'b0, 1'b1, 32'h300, 32'h1, 1'b1);
        idle(1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("abort busy", b2w(busy_o[0]), 32'd0);
        chk("abort ack",  b2w(ack_o[0]),  32'd0);
        idle(4);
        req(1'b1, 1'b0, 32'h300, 32'd0);
        chk("write survives reset", rd_o[0], 32'h1);

        // Back-to-back stream: the latency-1 instance acks every request.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 32'(i * 4), 32'(i), 1'b1);
            chk($sformatf("b2b wr ack %0d", i), b2w(ack_o[1]), 32'd1);
            chk($sformatf("b2b wr busy %0d", i), b2w(busy_o[1]), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b1);
            chk($sformatf("b2b rd ack %0d", i), b2w(ack_o[1]), 32'd1);
            chk($sformatf("b2b rd data %0d", i), rd_o[1], 32'(i));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
